// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo: turns retiring-instruction commit signals into numbered trace records,
//   buffers them in a DEPTH-entry FIFO and runs a RUN -> DRAIN -> DONE halt sequence.
// Latency: a commit seen at edge N reaches the FIFO head at edge N+1 at the earliest; no c_* -> rec_* path.
// Backpressure: rec_valid/rec_ready; when full with no pop, the new record is dropped and overflow sticks.
// Ports: clk/rst_n (async active-low); c_* commit inputs; rec_* record head plus handshake;
//   cycle_count/inst_count counters; fifo_level occupancy; overflow and halted status flags.
module commit_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       c_valid,
  input  logic [15:0]                c_pc,
  input  logic [15:0]                c_inst,
  input  logic                       c_regwrite,
  input  logic [2:0]                 c_wreg,
  input  logic [15:0]                c_wdata,
  input  logic                       c_memread,
  input  logic                       c_memwrite,
  input  logic [15:0]                c_memaddr,
  input  logic [15:0]                c_memdata,
  input  logic                       c_halt,
  output logic                       rec_valid,
  input  logic                       rec_ready,
  output logic [2:0]                 rec_kind,
  output logic [CNT_W-1:0]           rec_inum,
  output logic [15:0]                rec_pc,
  output logic [2:0]                 rec_reg,
  output logic [15:0]                rec_rval,
  output logic [15:0]                rec_addr,
  output logic [15:0]                rec_mval,
  output logic [CNT_W-1:0]           cycle_count,
  output logic [CNT_W-1:0]           inst_count,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow,
  output logic                       halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [2:0] K_NOP  = 3'd0;
  localparam logic [2:0] K_REG  = 3'd1;
  localparam logic [2:0] K_LD   = 3'd2;
  localparam logic [2:0] K_ST   = 3'd3;
  localparam logic [2:0] K_STU  = 3'd4;
  localparam logic [2:0] K_HALT = 3'd5;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_e;

  typedef struct packed {
    logic [2:0]       kind;
    logic [CNT_W-1:0] inum;
    logic [15:0]      pc;
    logic [2:0]       rreg;
    logic [15:0]      rval;
    logic [15:0]      addr;
    logic [15:0]      mval;
  } rec_t;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] inst_q, inst_d;
  logic             ovf_q, ovf_d;
  rec_t             mem_q [DEPTH];
  rec_t             new_rec;
  rec_t             head;
  logic             push, pop, full, wr_en;

  // The instruction word is carried on the port for future use only.
  logic unused_inst;
  assign unused_inst = ^c_inst;

  // Classification; fields a kind does not use stay zero.
  always_comb begin
    new_rec      = '0;
    new_rec.pc   = c_pc;
    new_rec.inum = inst_q;
    if (c_regwrite && c_memwrite) begin
      new_rec.kind = K_STU;
      new_rec.rreg = c_wreg;
      new_rec.rval = c_wdata;
      new_rec.addr = c_memaddr;
      new_rec.mval = c_memdata;
    end else if (c_regwrite && c_memread) begin
      new_rec.kind = K_LD;
      new_rec.rreg = c_wreg;
      new_rec.rval = c_wdata;
      new_rec.addr = c_memaddr;
    end else if (c_regwrite) begin
      new_rec.kind = K_REG;
      new_rec.rreg = c_wreg;
      new_rec.rval = c_wdata;
    end else if (c_halt) begin
      new_rec.kind = K_HALT;
    end else if (c_memwrite) begin
      new_rec.kind = K_ST;
      new_rec.addr = c_memaddr;
      new_rec.mval = c_memdata;
    end else begin
      new_rec.kind = K_NOP;
    end
  end

  assign push  = c_valid && (state_q == S_RUN);
  assign full  = (level_q == LVL_W'(DEPTH));
  assign pop   = (level_q != '0) && rec_ready;
  // At full a same-cycle pop frees the slot, so the push is kept.
  assign wr_en = push && (!full || pop);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q + LVL_W'(wr_en) - LVL_W'(pop);
    inst_d   = push ? inst_q + CNT_W'(1) : inst_q;
    ovf_d    = ovf_q || (push && full && !pop);
    cycle_d  = (state_q == S_DONE) ? cycle_q : cycle_q + CNT_W'(1);
    case (state_q)
      // A dropped HALT still ends the run.
      S_RUN:   if (push && new_rec.kind == K_HALT) state_d = S_DRAIN;
      // Uses the post-pop level so halted rises right after the last pop.
      S_DRAIN: if (level_d == '0) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cycle_q  <= '0;
      inst_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cycle_q  <= cycle_d;
      inst_q   <= inst_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= new_rec;
  end

  assign rec_valid = (level_q != '0);
  assign head      = rec_valid ? mem_q[rd_ptr_q] : '0;

  assign rec_kind    = head.kind;
  assign rec_inum    = head.inum;
  assign rec_pc      = head.pc;
  assign rec_reg     = head.rreg;
  assign rec_rval    = head.rval;
  assign rec_addr    = head.addr;
  assign rec_mval    = head.mval;
  assign cycle_count = cycle_q;
  assign inst_count  = inst_q;
  assign fifo_level  = level_q;
  assign overflow    = ovf_q;
  assign halted      = (state_q == S_DONE);

endmodule

// File: tb/tb_commit_trace_fifo.sv
// tb_commit_trace_fifo: directed table of single-cycle commit vectors plus hand-written
//   sequences for saturation, full push/pop, halt drain and asynchronous reset.
module tb_commit_trace_fifo;

  logic        clk, rst_n;
  logic        c_valid, c_regwrite, c_memread, c_memwrite, c_halt;
  logic [15:0] c_pc, c_inst, c_wdata, c_memaddr, c_memdata;
  logic [2:0]  c_wreg;
  logic        rec_valid, rec_ready;
  logic [2:0]  rec_kind, rec_reg;
  logic [31:0] rec_inum, cycle_count, inst_count;
  logic [15:0] rec_pc, rec_rval, rec_addr, rec_mval;
  logic [3:0]  fifo_level;
  logic        overflow, halted;

  int n_chk  = 0;
  int n_fail = 0;

  commit_trace_fifo #(.DEPTH(8), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_valid(c_valid), .c_pc(c_pc), .c_inst(c_inst), .c_regwrite(c_regwrite),
    .c_wreg(c_wreg), .c_wdata(c_wdata), .c_memread(c_memread), .c_memwrite(c_memwrite),
    .c_memaddr(c_memaddr), .c_memdata(c_memdata), .c_halt(c_halt),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_kind(rec_kind), .rec_inum(rec_inum),
    .rec_pc(rec_pc), .rec_reg(rec_reg), .rec_rval(rec_rval), .rec_addr(rec_addr),
    .rec_mval(rec_mval), .cycle_count(cycle_count), .inst_count(inst_count),
    .fifo_level(fifo_level), .overflow(overflow), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        cv, rw, mr, mw, ht;
    logic [2:0]  wreg;
    logic [15:0] pc, wdata, maddr, mdata;
    logic        vld;
    logic [2:0]  kind;
    logic [31:0] inum;
    logic [2:0]  rreg;
    logic [15:0] rval, addr, mval;
    logic [3:0]  lvl;
    logic [31:0] ic, cc;
    logic        hlt;
  } vec_t;

  vec_t tv [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cv, input logic rw, input logic mr, input logic mw,
                       input logic ht, input logic [2:0] wreg, input logic [15:0] pc,
                       input logic [15:0] wdata, input logic [15:0] maddr,
                       input logic [15:0] mdata);
    c_valid = cv; c_regwrite = rw; c_memread = mr; c_memwrite = mw; c_halt = ht;
    c_wreg = wreg; c_pc = pc; c_wdata = wdata; c_memaddr = maddr; c_memdata = mdata;
    c_inst = pc ^ 16'hA5A5;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic reg_commit(input logic [15:0] v);
    drive(1, 1, 0, 0, 0, v[2:0], v << 1, v, 16'h0, 16'h0);
  endtask

  logic [31:0] cc_prev;

  initial begin
    // rst, cv, rw, mr, mw, ht, wreg, pc, wdata, maddr, mdata |
    // vld, kind, inum, reg, rval, addr, mval, lvl, ic, cc, halted
    tv[0] = '{1,1,1,0,0,0,3'd3,16'h0002,16'h00AB,16'h0000,16'h0000,
              1,3'd1,0,3'd3,16'h00AB,16'h0000,16'h0000,4'd1,1,1,0};
    tv[1] = '{1,1,1,0,1,0,3'd2,16'h0010,16'h0010,16'h0020,16'h1234,
              1,3'd4,0,3'd2,16'h0010,16'h0020,16'h1234,4'd1,1,1,0};
    tv[2] = '{0,1,1,1,0,0,3'd1,16'h0012,16'hBEEF,16'h0040,16'h7777,
              1,3'd2,1,3'd1,16'hBEEF,16'h0040,16'h0000,4'd1,2,2,0};
    tv[3] = '{0,1,0,0,1,0,3'd6,16'h0014,16'h9999,16'h0050,16'h5555,
              1,3'd3,2,3'd0,16'h0000,16'h0050,16'h5555,4'd1,3,3,0};
    tv[4] = '{0,1,0,0,0,0,3'd5,16'h0016,16'h0001,16'h0123,16'h0456,
              1,3'd0,3,3'd0,16'h0000,16'h0000,16'h0000,4'd1,4,4,0};
    tv[5] = '{0,0,0,0,0,0,3'd0,16'h0000,16'h0000,16'h0000,16'h0000,
              0,3'd0,0,3'd0,16'h0000,16'h0000,16'h0000,4'd0,4,5,0};
    // all class bits set: STU must win over HALT, so the run continues
    tv[6] = '{0,1,1,1,1,1,3'd7,16'h0018,16'h1111,16'h2222,16'h3333,
              1,3'd4,4,3'd7,16'h1111,16'h2222,16'h3333,4'd1,5,6,0};
    tv[7] = '{0,1,1,0,0,0,3'd4,16'h001A,16'h4444,16'h0000,16'h0000,
              1,3'd1,5,3'd4,16'h4444,16'h0000,16'h0000,4'd1,6,7,0};
    // HALT beats plain memwrite
    tv[8] = '{0,1,0,0,1,1,3'd2,16'h001C,16'h5151,16'h6000,16'h7000,
              1,3'd5,6,3'd0,16'h0000,16'h0000,16'h0000,4'd1,7,8,0};
    // commit ignored in DRAIN; HALT record pops and the block reaches DONE
    tv[9] = '{0,1,1,0,0,0,3'd3,16'h001E,16'h00FF,16'h0000,16'h0000,
              0,3'd0,0,3'd0,16'h0000,16'h0000,16'h0000,4'd0,7,9,1};

    idle();
    rec_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("reset rec_valid", rec_valid, 0);
    chk("reset fifo_level", fifo_level, 0);
    chk("reset cycle_count", cycle_count, 0);
    chk("reset inst_count", inst_count, 0);
    chk("reset overflow", overflow, 0);
    chk("reset halted", halted, 0);
    chk("reset rec_inum", rec_inum, 0);
    rst_n = 1'b1;

    // ---- table-driven single-cycle vectors ----
    for (int i = 0; i < 10; i++) begin
      if (tv[i].rst) do_reset();
      drive(tv[i].cv, tv[i].rw, tv[i].mr, tv[i].mw, tv[i].ht, tv[i].wreg,
            tv[i].pc, tv[i].wdata, tv[i].maddr, tv[i].mdata);
      rec_ready = 1'b1;
      step();
      chk($sformatf("v%0d rec_valid", i), rec_valid, tv[i].vld);
      chk($sformatf("v%0d rec_kind", i), rec_kind, tv[i].kind);
      chk($sformatf("v%0d rec_inum", i), rec_inum, tv[i].inum);
      chk($sformatf("v%0d rec_pc", i), rec_pc, tv[i].vld ? tv[i].pc : 16'h0);
      chk($sformatf("v%0d rec_reg", i), rec_reg, tv[i].rreg);
      chk($sformatf("v%0d rec_rval", i), rec_rval, tv[i].rval);
      chk($sformatf("v%0d rec_addr", i), rec_addr, tv[i].addr);
      chk($sformatf("v%0d rec_mval", i), rec_mval, tv[i].mval);
      chk($sformatf("v%0d fifo_level", i), fifo_level, tv[i].lvl);
      chk($sformatf("v%0d inst_count", i), inst_count, tv[i].ic);
      chk($sformatf("v%0d cycle_count", i), cycle_count, tv[i].cc);
      chk($sformatf("v%0d halted", i), halted, tv[i].hlt);
      chk($sformatf("v%0d overflow", i), overflow, 0);
    end

    // ---- saturation: DEPTH+2 commits with the consumer stalled ----
    idle(); rec_ready = 1'b0; do_reset();
    for (int i = 0; i < 10; i++) begin
      reg_commit(16'(i));
      step();
      chk($sformatf("sat level %0d", i), fifo_level, (i < 8) ? i + 1 : 8);
      chk($sformatf("sat overflow %0d", i), overflow, (i >= 8) ? 1 : 0);
    end
    chk("sat inst_count", inst_count, 10);
    idle();
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall head inum", rec_inum, 0);
      chk("stall head rval", rec_rval, 0);
      chk("stall level", fifo_level, 8);
    end
    rec_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("sat pop inum %0d", k), rec_inum, k);
      chk($sformatf("sat pop rval %0d", k), rec_rval, k);
      step();
    end
    chk("sat drained valid", rec_valid, 0);
    chk("sat drained level", fifo_level, 0);
    chk("sat overflow sticky", overflow, 1);

    // ---- push and pop together at full ----
    idle(); rec_ready = 1'b0; do_reset();
    for (int i = 0; i < 8; i++) begin
      reg_commit(16'(i));
      step();
    end
    chk("full level", fifo_level, 8);
    reg_commit(16'hCAFE);
    rec_ready = 1'b1;
    step();
    chk("full pp level", fifo_level, 8);
    chk("full pp overflow", overflow, 0);
    chk("full pp inst_count", inst_count, 9);
    idle();
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("full pop inum %0d", k), rec_inum, k);
      if (k == 8) chk("full kept rval", rec_rval, 16'hCAFE);
      step();
    end
    chk("full drained level", fifo_level, 0);

    // ---- halt and drain with a stalled consumer ----
    idle(); rec_ready = 1'b0; do_reset();
    for (int i = 0; i < 3; i++) begin
      reg_commit(16'(i + 1));
      step();
    end
    drive(1, 0, 0, 0, 1, 3'd0, 16'h0100, 16'h0, 16'h0, 16'h0);
    step();
    chk("halt level", fifo_level, 4);
    chk("halt inst_count", inst_count, 4);
    for (int i = 0; i < 5; i++) begin
      reg_commit(16'h0077);
      cc_prev = cycle_count;
      step();
      chk($sformatf("drain cc %0d", i), cycle_count, cc_prev + 1);
      chk($sformatf("drain level %0d", i), fifo_level, 4);
      chk($sformatf("drain ic %0d", i), inst_count, 4);
      chk($sformatf("drain halted %0d", i), halted, 0);
    end
    idle(); rec_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain pop inum %0d", k), rec_inum, k);
      if (k == 3) chk("drain halt kind", rec_kind, 5);
      step();
      chk($sformatf("drain halted after %0d", k), halted, (k == 3) ? 1 : 0);
    end
    cc_prev = cycle_count;
    reg_commit(16'h0033);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("done cc frozen %0d", i), cycle_count, cc_prev);
      chk($sformatf("done ic %0d", i), inst_count, 4);
      chk($sformatf("done valid %0d", i), rec_valid, 0);
      chk($sformatf("done halted %0d", i), halted, 1);
    end

    // ---- asynchronous reset mid-drain ----
    idle(); rec_ready = 1'b0; do_reset();
    for (int i = 0; i < 3; i++) begin
      reg_commit(16'(i + 5));
      step();
    end
    drive(1, 0, 0, 0, 1, 3'd0, 16'h0200, 16'h0, 16'h0, 16'h0);
    step();
    idle();
    chk("pre-reset level", fifo_level, 4);
    rst_n = 1'b0;
    #1;
    chk("arst rec_valid", rec_valid, 0);
    chk("arst level", fifo_level, 0);
    chk("arst inst_count", inst_count, 0);
    chk("arst cycle_count", cycle_count, 0);
    chk("arst halted", halted, 0);
    chk("arst rec_inum", rec_inum, 0);
    chk("arst rec_pc", rec_pc, 0);
    #1;
    rst_n = 1'b1;
    rec_ready = 1'b1;
    reg_commit(16'h0042);
    step();
    chk("post-reset valid", rec_valid, 1);
    chk("post-reset inum", rec_inum, 0);
    chk("post-reset rval", rec_rval, 16'h0042);
    chk("post-reset ic", inst_count, 1);
    chk("post-reset cc", cycle_count, 1);
    chk("post-reset halted", halted, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
